// File: rtl/muldiv_pkg.sv
// Shared types, constants and op-decoding helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input md_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // rs1 is treated as two's complement for these ops
    function automatic logic is_signed_a(input md_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic is_signed_b(input md_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: operand signs, magnitudes and the two
// divide special cases that bypass the iterative datapath.
module muldiv_operand_prep
    import muldiv_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            sign_a,
    output logic            sign_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            div_zero,
    output logic            div_ovf
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_op_e op_e;
    assign op_e = md_op_e'(op);

    assign sign_a = is_signed_a(op_e) && rs1_data[XLEN-1];
    assign sign_b = is_signed_b(op_e) && rs2_data[XLEN-1];

    // The most negative value maps onto itself, which is the correct unsigned magnitude
    assign mag_a = sign_a ? (~rs1_data + 1'b1) : rs1_data;
    assign mag_b = sign_b ? (~rs2_data + 1'b1) : rs2_data;

    assign div_zero = is_div(op_e) && (rs2_data == '0);
    assign div_ovf  = (op_e == OP_DIV || op_e == OP_REM) &&
                      (rs1_data == MOST_NEG) && (rs2_data == '1);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one op at a time, 32 iteration cycles,
// a sign-fix cycle, then a held write request toward the register file.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_kill,
    output logic            o_rd_wren,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    input  logic            i_wb_ready
);

    md_state_e state_reg, state_next;

    md_op_e            op_reg;
    logic [4:0]        rd_reg;
    logic              sign_a_reg;
    logic              sign_b_reg;
    logic [XLEN-1:0]   mag_a_reg;
    logic [XLEN-1:0]   mag_b_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   result_reg;
    logic              wren_reg;
    logic [4:0]        addr_reg;
    logic [XLEN-1:0]   data_reg;

    logic              prep_sign_a;
    logic              prep_sign_b;
    logic [XLEN-1:0]   prep_mag_a;
    logic [XLEN-1:0]   prep_mag_b;
    logic              prep_div_zero;
    logic              prep_div_ovf;

    md_op_e            op_in;
    logic              accept;
    logic              launch;
    logic              write_fire;
    logic [XLEN-1:0]   special_result;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   fix_result;

    muldiv_operand_prep u_prep (
        .op       (i_op),
        .rs1_data (i_rs1_data),
        .rs2_data (i_rs2_data),
        .sign_a   (prep_sign_a),
        .sign_b   (prep_sign_b),
        .mag_a    (prep_mag_a),
        .mag_b    (prep_mag_b),
        .div_zero (prep_div_zero),
        .div_ovf  (prep_div_ovf)
    );

    assign op_in   = md_op_e'(i_op);
    assign o_ready = (state_reg == ST_IDLE);
    // rd==0 ops are handshaken but never enter the datapath
    assign launch  = accept && (i_rd_addr != 5'd0);

    assign o_rd_wren = wren_reg;
    assign o_rd_addr = addr_reg;
    assign o_rd_data = data_reg;

    // Divide special cases: zero divisor and signed overflow, resolved at accept time
    always_comb begin
        special_result = '0;
        if (prep_div_zero) begin
            special_result = is_rem(op_in) ? i_rs1_data : '1;
        end else begin
            special_result = is_rem(op_in) ? '0 : i_rs1_data;
        end
    end

    // Next-state logic; kill overrides every transition including accept and write
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        write_fire = 1'b0;
        if (i_kill) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        accept = 1'b1;
                        if (i_rd_addr != 5'd0) begin
                            state_next = (prep_div_zero || prep_div_ovf) ? ST_DONE : ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt_reg == CNT_W'(XLEN-1)) begin
                        state_next = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_next = ST_DONE;
                end
                ST_DONE: begin
                    if (wren_reg && i_wb_ready) begin
                        state_next = ST_IDLE;
                        write_fire = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} +
                    (prod_reg[0] ? {1'b0, mag_a_reg} : {(XLEN+1){1'b0}});
        prod_step = {mul_sum, prod_reg[XLEN-1:1]};
        div_shift = {rem_reg, quo_reg[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b_reg};
        if (div_diff[XLEN+1]) begin
            rem_step = div_shift[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b0};
        end else begin
            rem_step = div_diff[XLEN-1:0];
            quo_step = {quo_reg[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection applied in the FIX cycle
    always_comb begin
        prod_fixed = (sign_a_reg ^ sign_b_reg) ? (~prod_reg + 1'b1) : prod_reg;
        quo_fixed  = (sign_a_reg ^ sign_b_reg) ? (~quo_reg + 1'b1) : quo_reg;
        rem_fixed  = sign_a_reg ? (~rem_reg + 1'b1) : rem_reg;
        if (is_div(op_reg)) begin
            fix_result = is_rem(op_reg) ? rem_fixed : quo_fixed;
        end else if (op_reg == OP_MUL) begin
            fix_result = prod_fixed[XLEN-1:0];
        end else begin
            fix_result = prod_fixed[2*XLEN-1:XLEN];
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_reg     <= OP_MUL;
            rd_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            prod_reg   <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else if (launch) begin
            op_reg     <= op_in;
            rd_reg     <= i_rd_addr;
            sign_a_reg <= prep_sign_a;
            sign_b_reg <= prep_sign_b;
            mag_a_reg  <= prep_mag_a;
            mag_b_reg  <= prep_mag_b;
            prod_reg   <= {{XLEN{1'b0}}, prep_mag_b};
            rem_reg    <= '0;
            quo_reg    <= prep_mag_a;
            cnt_reg    <= '0;
            result_reg <= special_result;
        end else if (state_reg == ST_CALC && !i_kill) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_div(op_reg)) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
            end else begin
                prod_reg <= prod_step;
            end
        end else if (state_reg == ST_FIX) begin
            result_reg <= fix_result;
        end
    end

    // Write request: raised one cycle into DONE, held until the write port grants it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wren_reg <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (i_kill || write_fire) begin
            wren_reg <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            wren_reg <= 1'b1;
            addr_reg <= rd_reg;
            data_reg <= result_reg;
        end
    end

endmodule
